// File: rtl/megarom_pkg.sv
// rtl/megarom_pkg.sv - shared types and address constants for the MegaROM mapper
package megarom_pkg;

  typedef enum logic [1:0] {
    PLAIN    = 2'd0,
    ASCII8   = 2'd1,
    KONAMI   = 2'd2,
    RESERVED = 2'd3
  } mapper_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fsm_state_t;

  localparam logic [15:0] PAGE_BASE = 16'h4000;
  localparam logic [15:0] PAGE_TOP  = 16'hBFFF;

  // ASCII8 selects the bank with addr[12:11]; Konami selects it by the 8 KB page written
  localparam logic [15:0] A8_BANK_LO     = 16'h6000;
  localparam logic [15:0] A8_BANK_HI     = 16'h7FFF;
  localparam logic [15:0] KONAMI_BANK_LO = 16'h6000;
  localparam logic [15:0] KONAMI_BANK_HI = 16'hBFFF;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Page index 0..3 for 0x4000..0xBFFF: (addr[15:13] - 2) reduces to flipping bit 14
  function automatic logic [1:0] page_of(input logic [15:0] a);
    return a[14:13] ^ 2'b10;
  endfunction

endpackage

// File: rtl/mapper_bank_regs.sv
// rtl/mapper_bank_regs.sv - four 8 KB bank registers with mode-dependent write decode
module mapper_bank_regs
  import megarom_pkg::*;
#(
  parameter int BANK_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic                 wr_start,
  input  logic [15:0]          wr_addr,
  input  logic [BANK_BITS-1:0] wr_data,
  input  logic [1:0]           page,
  output logic [BANK_BITS-1:0] bank
);

  logic [BANK_BITS-1:0] regs [4];
  mapper_mode_t         mode_e;
  logic                 wr_en;
  logic [1:0]           wr_sel;

  always_comb begin
    mode_e = mapper_mode_t'(mode);
    wr_en  = 1'b0;
    wr_sel = 2'd0;
    case (mode_e)
      ASCII8: begin
        if (in_range(wr_addr, A8_BANK_LO, A8_BANK_HI)) begin
          wr_en  = wr_start;
          wr_sel = wr_addr[12:11];
        end
      end
      KONAMI: begin
        // 0x6000.. lands on page 1, so bank0 can never be selected here
        if (in_range(wr_addr, KONAMI_BANK_LO, KONAMI_BANK_HI)) begin
          wr_en  = wr_start;
          wr_sel = page_of(wr_addr);
        end
      end
      default: begin
        wr_en  = 1'b0;
        wr_sel = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= BANK_BITS'(i);
      end
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // Konami pins page 0 to bank 0 regardless of what ASCII8 may have left in regs[0]
  always_comb begin
    if (mode_e == KONAMI && page == 2'd0) begin
      bank = '0;
    end else begin
      bank = regs[page];
    end
  end

endmodule

// File: rtl/megarom_mapper.sv
// rtl/megarom_mapper.sv - cartridge bus front end translating CPU reads into ROM fetches
module megarom_mapper
  import megarom_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int BANK_BITS  = ADDR_WIDTH - 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            mapper_mode,
  input  logic                  sltsl_n,
  input  logic                  cpu_rd_n,
  input  logic                  cpu_wr_n,
  input  logic [15:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_dout_oe,
  output logic                  wait_n
);

  fsm_state_t           state;
  logic                 rd_act;
  logic                 wr_act;
  logic                 rd_idle;
  logic                 wr_idle;
  logic                 rd_start;
  logic                 wr_start;
  logic                 page_valid;
  logic [1:0]           page;
  logic [BANK_BITS-1:0] bank;
  logic [15:0]          lin_off;
  logic [ADDR_WIDTH-1:0] mapped_addr;

  // Both strobes low at once is treated as bus contention: neither counts
  assign rd_act   = !sltsl_n && !cpu_rd_n && cpu_wr_n;
  assign wr_act   = !sltsl_n && !cpu_wr_n && cpu_rd_n;
  assign rd_start = rd_act && rd_idle;
  assign wr_start = wr_act && wr_idle;

  assign page_valid = in_range(cpu_addr, PAGE_BASE, PAGE_TOP);
  assign page       = page_of(cpu_addr);
  assign lin_off    = cpu_addr - PAGE_BASE;

  mapper_bank_regs #(
    .BANK_BITS(BANK_BITS)
  ) u_bank_regs (
    .clock    (clock),
    .reset_n  (reset_n),
    .mode     (mapper_mode),
    .wr_start (wr_start),
    .wr_addr  (cpu_addr),
    .wr_data  (BANK_BITS'(cpu_din)),
    .page     (page),
    .bank     (bank)
  );

  always_comb begin
    case (mapper_mode_t'(mapper_mode))
      ASCII8, KONAMI: mapped_addr = ADDR_WIDTH'({bank, cpu_addr[12:0]});
      default:        mapped_addr = ADDR_WIDTH'(lin_off);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_idle     <= 1'b1;
      wr_idle     <= 1'b1;
      rom_address <= '0;
      rom_enable  <= 1'b0;
      cpu_dout    <= '0;
      cpu_dout_oe <= 1'b0;
      wait_n      <= 1'b1;
    end else begin
      rd_idle <= !rd_act;
      wr_idle <= !wr_act;
      case (state)
        IDLE: begin
          if (rd_start && page_valid) begin
            rom_address <= mapped_addr;
            rom_enable  <= 1'b1;
            wait_n      <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          rom_enable <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          cpu_dout    <= rom_q;
          cpu_dout_oe <= 1'b1;
          wait_n      <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          // A read that already ended still gets one HOLD cycle before release
          if (!rd_act) begin
            cpu_dout_oe <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_megarom_mapper.sv
// tb/tb_megarom_mapper.sv - self-checking bench for megarom_mapper
module tb_megarom_mapper;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    mapper_mode;
  logic          sltsl_n;
  logic          cpu_rd_n;
  logic          cpu_wr_n;
  logic [15:0]   cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [AW-1:0] rom_address;
  logic          rom_enable;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] cpu_dout;
  logic          cpu_dout_oe;
  logic          wait_n;

  always #5 clock = ~clock;

  megarom_mapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mapper_mode (mapper_mode),
    .sltsl_n     (sltsl_n),
    .cpu_rd_n    (cpu_rd_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .rom_address (rom_address),
    .rom_enable  (rom_enable),
    .rom_q       (rom_q),
    .cpu_dout    (cpu_dout),
    .cpu_dout_oe (cpu_dout_oe),
    .wait_n      (wait_n)
  );

  // Registered ROM model: contents are a fixed pattern of the address
  initial rom_q = '0;
  always @(posedge clock) if (rom_enable) rom_q <= rom_address[7:0] ^ 8'h5A;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout;
  int r_en, r_wait, r_oec;
  logic r_oe_after;

  task automatic push_exp(input logic [AW-1:0] a);
    exp_t x;
    x.addr = a;
    x.data = a[7:0] ^ 8'h5A;
    sb.push_back(x);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic slot_n);
    @(negedge clock);
    sltsl_n = slot_n; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1; cpu_addr = a;
    r_en = 0; r_wait = 0; r_oec = 0; r_addr = '0; r_dout = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (rom_enable) begin r_en++; r_addr = rom_address; end
      if (!wait_n) r_wait++;
      if (cpu_dout_oe && r_oec == 0) begin r_oec = k; r_dout = cpu_dout; end
    end
    sltsl_n = 1'b1; cpu_rd_n = 1'b1;
    @(negedge clock);
    r_oe_after = cpu_dout_oe;
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    sltsl_n = 1'b0; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clock);
    sltsl_n = 1'b1; cpu_wr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mapper_mode = 2'd0; sltsl_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    cpu_addr = '0; cpu_din = '0;
    repeat (3) @(negedge clock);
    checks++; if (rom_address !== '0) begin errors++; $display("FAIL rst_addr got=%h exp=0", rom_address); end
    checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", rom_enable); end
    checks++; if (cpu_dout !== '0) begin errors++; $display("FAIL rst_dout got=%h exp=0", cpu_dout); end
    checks++; if (cpu_dout_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b exp=0", cpu_dout_oe); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait got=%b exp=1", wait_n); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ascii8_basic();
    mapper_mode = 2'd1;
    push_exp(17'h00000);
    bus_read(16'h4000, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL a8_addr got=%h exp=%h", r_addr, e.addr); end
    checks++; if (r_en !== 1) begin errors++; $display("FAIL a8_en_cycles got=%0d exp=1", r_en); end
    checks++; if (r_dout !== e.data) begin errors++; $display("FAIL a8_dout got=%h exp=%h", r_dout, e.data); end
    checks++; if (r_oec !== 3) begin errors++; $display("FAIL a8_oe_latency got=%0d exp=3", r_oec); end
    checks++; if (r_wait !== 2) begin errors++; $display("FAIL a8_wait_cycles got=%0d exp=2", r_wait); end
    checks++; if (r_oe_after !== 1'b0) begin errors++; $display("FAIL a8_oe_release got=%b exp=0", r_oe_after); end
  endtask

  task automatic test_ascii8_banks();
    mapper_mode = 2'd1;
    bus_write(16'h6800, 8'h05);
    push_exp(17'h0A123);
    bus_read(16'h6123, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL a8_bank1 got=%h exp=%h", r_addr, e.addr); end
    checks++; if (r_dout !== e.data) begin errors++; $display("FAIL a8_bank1_dout got=%h exp=%h", r_dout, e.data); end
    bus_write(16'h7000, 8'hFF);
    push_exp(17'h1E001);
    bus_read(16'h8001, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL a8_bank2_wrap got=%h exp=%h", r_addr, e.addr); end
  endtask

  task automatic test_konami();
    mapper_mode = 2'd2;
    bus_write(16'h5000, 8'h03);
    push_exp(17'h00010);
    bus_read(16'h4010, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL kon_bank0_fixed got=%h exp=%h", r_addr, e.addr); end
    bus_write(16'hA000, 8'h07);
    push_exp(17'h0F000);
    bus_read(16'hB000, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL kon_bank3 got=%h exp=%h", r_addr, e.addr); end
    checks++; if (r_dout !== e.data) begin errors++; $display("FAIL kon_bank3_dout got=%h exp=%h", r_dout, e.data); end
  endtask

  task automatic test_plain();
    mapper_mode = 2'd0;
    push_exp(17'h07FFF);
    bus_read(16'hBFFF, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL plain_top got=%h exp=%h", r_addr, e.addr); end
    checks++; if (r_dout !== e.data) begin errors++; $display("FAIL plain_top_dout got=%h exp=%h", r_dout, e.data); end
    bus_read(16'h3FFF, 1'b0);
    checks++; if (r_en !== 0 || r_oec !== 0 || r_wait !== 0) begin errors++; $display("FAIL plain_below en=%0d oe=%0d wait=%0d exp=0/0/0", r_en, r_oec, r_wait); end
    bus_read(16'hC000, 1'b0);
    checks++; if (r_en !== 0 || r_oec !== 0 || r_wait !== 0) begin errors++; $display("FAIL plain_above en=%0d oe=%0d wait=%0d exp=0/0/0", r_en, r_oec, r_wait); end
    mapper_mode = 2'd3;
    push_exp(17'h02000);
    bus_read(16'h6000, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL reserved_linear got=%h exp=%h", r_addr, e.addr); end
  endtask

  task automatic test_contention();
    int en_cnt, wait_cnt;
    mapper_mode = 2'd1;
    en_cnt = 0; wait_cnt = 0;
    @(negedge clock);
    sltsl_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 16'h6800; cpu_din = 8'h09;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (rom_enable) en_cnt++;
      if (!wait_n) wait_cnt++;
    end
    sltsl_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    @(negedge clock);
    checks++; if (en_cnt !== 0 || wait_cnt !== 0) begin errors++; $display("FAIL both_low_access en=%0d wait=%0d exp=0/0", en_cnt, wait_cnt); end
    push_exp(17'h0A000);
    bus_read(16'h6000, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL both_low_no_write got=%h exp=%h", r_addr, e.addr); end
    bus_read(16'h4000, 1'b1);
    checks++; if (r_en !== 0 || r_oec !== 0) begin errors++; $display("FAIL no_slot en=%0d oe=%0d exp=0/0", r_en, r_oec); end
  endtask

  task automatic test_back_to_back();
    mapper_mode = 2'd1;
    bus_write(16'h6000, 8'h03);
    push_exp(17'h06005);
    push_exp(17'h06006);
    bus_read(16'h4005, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL b2b_first got=%h exp=%h", r_addr, e.addr); end
    bus_read(16'h4006, 1'b0);
    e = sb.pop_front();
    checks++; if (r_addr !== e.addr || r_dout !== e.data) begin errors++; $display("FAIL b2b_second addr=%h dout=%h exp=%h/%h", r_addr, r_dout, e.addr, e.data); end
  endtask

  task automatic test_reset_mid();
    mapper_mode = 2'd1;
    @(negedge clock);
    sltsl_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h4000;
    @(negedge clock);
    checks++; if (rom_enable !== 1'b1) begin errors++; $display("FAIL mid_in_fetch en=%b exp=1", rom_enable); end
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if (cpu_dout_oe !== 1'b0 || wait_n !== 1'b1 || rom_enable !== 1'b0) begin errors++; $display("FAIL mid_reset oe=%b wait=%b en=%b exp=0/1/0", cpu_dout_oe, wait_n, rom_enable); end
    sltsl_n = 1'b1; cpu_rd_n = 1'b1; reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) push_exp(AW'(i) << 13 | AW'(i) << 13);
    for (int i = 0; i < 4; i++) begin
      bus_read(16'h4000 + 16'(i) * 16'h2000, 1'b0);
      e = sb.pop_front();
      checks++; if (r_addr !== e.addr) begin errors++; $display("FAIL reset_bank%0d got=%h exp=%h", i, r_addr, e.addr); end
    end
  endtask

  initial begin
    test_reset();
    test_ascii8_basic();
    test_ascii8_banks();
    test_konami();
    test_plain();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/megarom_mapper.md
Name: megarom_mapper

Overview:
- Cartridge-side bus front end that sits directly upstream of the ROM block.
- Detects slot read/write cycles from the already-synchronised cartridge bus and decodes bank-register writes for the selected MegaROM mapper.
- Translates CPU addresses 0x4000-0xBFFF into ROM addresses and issues a one-cycle ROM enable.
- Captures the ROM's registered data and drives it back to the bus, holding wait_n low until the data is valid.

Parameters:
- ADDR_WIDTH, 17, ROM address width in bytes (128 KB); must be >= 14.
- BANK_BITS, ADDR_WIDTH-13, width of each 8 KB bank register.
- DATA_WIDTH, 8, data width; must match the ROM.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- mapper_mode  in  2  0=plain linear, 1=ASCII8, 2=Konami (no SCC), 3=reserved (treated as plain).
- sltsl_n  in  1  slot select, active-low, synchronised.
- cpu_rd_n  in  1  read strobe, active-low, synchronised.
- cpu_wr_n  in  1  write strobe, active-low, synchronised.
- cpu_addr  in  16  CPU address.
- cpu_din  in  DATA_WIDTH  CPU write data.
- rom_address  out  ADDR_WIDTH  address to the ROM, registered.
- rom_enable  out  1  ROM read enable, registered, one-cycle pulse.
- rom_q  in  DATA_WIDTH  ROM data; valid the cycle after rom_enable.
- cpu_dout  out  DATA_WIDTH  read data to the bus.
- cpu_dout_oe  out  1  bus drive enable for cpu_dout.
- wait_n  out  1  active-low wait to the CPU.

Behaviour:
- Clock and reset: one clock (clock). reset_n is synchronous and active-low.
- Reset values:
  - rom_address=0, rom_enable=0, cpu_dout=0, cpu_dout_oe=0, wait_n=1.
  - FSM=IDLE.
  - bank[i]=i for i=0..3.
  - Previous-strobe registers = 1 (inactive).
- Strobe qualification:
  - rd_act = !sltsl_n && !cpu_rd_n && cpu_wr_n.
  - wr_act = !sltsl_n && !cpu_wr_n && cpu_rd_n.
  - If rd and wr are low together, neither is active.
  - A start is the 0->1 transition of rd_act or wr_act versus the previous cycle.
- Page decode: page p = cpu_addr[15:13]-2, valid only for cpu_addr in 0x4000-0xBFFF (p=0..3). Outside that range there is no ROM access, no wait, and no drive.
- Address mapping:
  - plain/reserved: rom_address = (cpu_addr - 0x4000) truncated to ADDR_WIDTH.
  - ASCII8/Konami: rom_address = {bank[p], cpu_addr[12:0]} truncated to ADDR_WIDTH.
- Bank writes, decoded on a wr start only; writes in other ranges are ignored:
  - ASCII8: 0x6000-0x67FF -> bank0, 0x6800-0x6FFF -> bank1, 0x7000-0x77FF -> bank2, 0x7800-0x7FFF -> bank3.
  - Konami: 0x6000-0x7FFF -> bank1, 0x8000-0x9FFF -> bank2, 0xA000-0xBFFF -> bank3. bank0 is fixed at 0 and cannot be written.
  - plain: all writes are ignored.
  - Stored value = cpu_din[BANK_BITS-1:0]; upper bits are discarded (wrap modulo 2^BANK_BITS).
  - The new value takes effect for any read starting on a later cycle.
- FSM:
  - IDLE:
    - On a valid rd start (cycle T): register rom_address, set rom_enable=1 and wait_n=0, go to FETCH.
    - mapper_mode and the bank registers are sampled at T.
  - FETCH (T+1):
    - Drop rom_enable to 0, keep wait_n=0, go to CAPTURE.
    - The ROM presents rom_q during this cycle.
  - CAPTURE (T+2):
    - Latch cpu_dout <= rom_q, set cpu_dout_oe=1 and wait_n=1, go to HOLD.
  - HOLD:
    - Keep cpu_dout and cpu_dout_oe while rd_act=1.
    - When rd_act=0, clear cpu_dout_oe, go to IDLE.
    - A bus read that ends before CAPTURE still runs through CAPTURE and into HOLD, then exits HOLD on the next cycle.
- Latency: rd start to data valid = 2 clocks (cpu_dout_oe high in cycle T+3 as seen at outputs).
- Write handling and restarts:
  - Writes (bank decode) are accepted in any FSM state.
  - A new rd start can only be taken in IDLE; an rd start in another state is ignored.
  - rom_enable is never high in two consecutive cycles.
- mapper_mode changes apply at the next access start. Bank registers are not reset by a mode change.
- A reset_n low in any state forces all reset values at that edge, including bank registers. wait_n=1 at the next edge.

Decomposition:
- Package megarom_pkg holds:
  - mapper_mode_t enum (PLAIN, ASCII8, KONAMI, RESERVED).
  - fsm_state_t enum (IDLE, FETCH, CAPTURE, HOLD).
  - PAGE_BASE=16'h4000 and PAGE_TOP=16'hBFFF constants.
  - The per-mode bank-write address ranges as constants.
- One sub-module, mapper_bank_regs:
  - Four BANK_BITS registers with reset values.
  - Mode-dependent write decode.
  - Combinational bank[p] read-out.
- The top module holds strobe-edge detection, the FSM and the ROM/bus outputs.

Test Plan:
- Reset, then mode=ASCII8 and read 0x4000 -> rom_address=0x00000. rom_enable is high for exactly 1 cycle. With rom_q=0x5A, cpu_dout=0x5A and oe=1 two cycles after the start, and wait_n is low for exactly 2 cycles.
- ASCII8: write 0x05 to 0x6800, then read 0x6123 -> rom_address=0x0A123. Write 0xFF to 0x7000 with ADDR_WIDTH=17, then read 0x8001 -> bank2=0x0F and rom_address=0x1E001.
- Konami:
  - Write 0x03 to 0x5000 -> bank0 stays 0; a read at 0x4010 gives rom_address=0x00010.
  - Write 0x07 to 0xA000 -> a read at 0xB000 gives rom_address=0x0F000.
- Plain mode: read 0xBFFF -> rom_address=0x7FFF. Read 0x3FFF or 0xC000 -> no rom_enable, oe=0, wait_n=1.
- cpu_rd_n and cpu_wr_n both low with slot selected -> no bank write, no ROM access. A read with sltsl_n=1 -> no access.
- Assert reset_n low during FETCH -> next edge gives oe=0, wait_n=1 and FSM=IDLE. After release, bank registers read back 0,1,2,3.
